sal_sched_arbiter: RTL and testbench



---
 rtl/sal_sched_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_sal_sched_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sal_sched_arbiter.sv
// sal_sched_arbiter: inter-bank command arbiter between the per-bank schedulers and the DFI
// command encoder. Grants at most one ACT/RD/WR/PRE/REF per cycle using fixed class priority
// (CAS > ACT > PRE > REF) and round-robin across banks, enforcing tRRD, tCCD, tWTR, tRTW and,
// optionally, tFAW. The granted command is registered and presented one cycle later.
//
// Optional feature macro: SAL_FAW_EN adds the t_faw_m1_i port and four-activate-window tracking.
//
// Ports:
//   clk_i, rst_ni                      clock, synchronous active-low reset
//   {act,rd,wr,pre,ref}_req_i          per-bank requests (bit i = bank i)
//   ra_i, ca_i, id_i, len_i            per-bank packed command fields (slice i = bank i)
//   {act,rd,wr,pre,ref}_gnt_o          combinational grants, at most one bit set overall
//   t_{rrd,ccd,wtr,rtw}_m1_i           timing values minus one, sampled when a counter loads
//   t_faw_m1_i                         tFAW minus one (SAL_FAW_EN only)
//   cmd_*_o                            registered granted command
module sal_sched_arbiter #(
  parameter int unsigned NUM_BANKS = 16,
  parameter int unsigned RA_WIDTH  = 16,
  parameter int unsigned CA_WIDTH  = 10,
  parameter int unsigned ID_WIDTH  = 4,
  parameter int unsigned LEN_WIDTH = 8,
  parameter int unsigned CNT_WIDTH = 8,
  localparam int unsigned BA_WIDTH = $clog2(NUM_BANKS)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_BANKS-1:0]           act_req_i,
  input  logic [NUM_BANKS-1:0]           rd_req_i,
  input  logic [NUM_BANKS-1:0]           wr_req_i,
  input  logic [NUM_BANKS-1:0]           pre_req_i,
  input  logic [NUM_BANKS-1:0]           ref_req_i,
  input  logic [NUM_BANKS*RA_WIDTH-1:0]  ra_i,
  input  logic [NUM_BANKS*CA_WIDTH-1:0]  ca_i,
  input  logic [NUM_BANKS*ID_WIDTH-1:0]  id_i,
  input  logic [NUM_BANKS*LEN_WIDTH-1:0] len_i,
  output logic [NUM_BANKS-1:0]           act_gnt_o,
  output logic [NUM_BANKS-1:0]           rd_gnt_o,
  output logic [NUM_BANKS-1:0]           wr_gnt_o,
  output logic [NUM_BANKS-1:0]           pre_gnt_o,
  output logic [NUM_BANKS-1:0]           ref_gnt_o,
  input  logic [CNT_WIDTH-1:0]           t_rrd_m1_i,
  input  logic [CNT_WIDTH-1:0]           t_ccd_m1_i,
  input  logic [CNT_WIDTH-1:0]           t_wtr_m1_i,
  input  logic [CNT_WIDTH-1:0]           t_rtw_m1_i,
`ifdef SAL_FAW_EN
  input  logic [CNT_WIDTH-1:0]           t_faw_m1_i,
`endif
  output logic                           cmd_valid_o,
  output logic [2:0]                     cmd_type_o,
  output logic [BA_WIDTH-1:0]            cmd_ba_o,
  output logic [RA_WIDTH-1:0]            cmd_ra_o,
  output logic [CA_WIDTH-1:0]            cmd_ca_o,
  output logic [ID_WIDTH-1:0]            cmd_id_o,
  output logic [LEN_WIDTH-1:0]           cmd_len_o
);

  typedef enum logic [2:0] {CmdAct = 3'd0, CmdRd = 3'd1, CmdWr = 3'd2, CmdPre = 3'd3,
                            CmdRef = 3'd4} cmd_e;

  logic [CNT_WIDTH-1:0] rrd_cnt_q, rrd_cnt_d, ccd_cnt_q, ccd_cnt_d;
  logic [CNT_WIDTH-1:0] wtr_cnt_q, wtr_cnt_d, rtw_cnt_q, rtw_cnt_d;
  logic [BA_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;

  logic                 cmd_valid_q, cmd_valid_d;
  logic [2:0]           cmd_type_q, cmd_type_d;
  logic [BA_WIDTH-1:0]  cmd_ba_q, cmd_ba_d;
  logic [RA_WIDTH-1:0]  cmd_ra_q, cmd_ra_d;
  logic [CA_WIDTH-1:0]  cmd_ca_q, cmd_ca_d;
  logic [ID_WIDTH-1:0]  cmd_id_q, cmd_id_d;
  logic [LEN_WIDTH-1:0] cmd_len_q, cmd_len_d;

  logic                 act_ok, rd_ok, wr_ok;
  logic [NUM_BANKS-1:0] rd_elig, wr_elig, cas_elig, act_elig, win_mask;
  logic [BA_WIDTH-1:0]  idx, sel_ba;
  logic                 sel_found, gnt_valid;
  cmd_e                 sel_type;

`ifdef SAL_FAW_EN
  // One slot per ACT in the rolling window; wptr points at the oldest of the last four.
  logic [3:0][CNT_WIDTH-1:0] faw_cnt_q, faw_cnt_d;
  logic [1:0]                faw_wptr_q, faw_wptr_d;
  assign act_ok = (rrd_cnt_q == '0) && (faw_cnt_q[faw_wptr_q] == '0);
`else
  assign act_ok = (rrd_cnt_q == '0);
`endif
  assign rd_ok = (ccd_cnt_q == '0) && (wtr_cnt_q == '0);
  assign wr_ok = (ccd_cnt_q == '0) && (rtw_cnt_q == '0);

  // Class select on eligible requesters only, so a timing-blocked class never starves lower ones.
  always_comb begin
    rd_elig   = rd_req_i & {NUM_BANKS{rd_ok}};
    wr_elig   = wr_req_i & {NUM_BANKS{wr_ok}};
    cas_elig  = rd_elig | wr_elig;
    act_elig  = act_req_i & {NUM_BANKS{act_ok}};
    win_mask  = ref_req_i;
    sel_type  = CmdRef;
    if (|cas_elig) begin
      win_mask = cas_elig;
      sel_type = CmdRd;
    end else if (|act_elig) begin
      win_mask = act_elig;
      sel_type = CmdAct;
    end else if (|pre_req_i) begin
      win_mask = pre_req_i;
      sel_type = CmdPre;
    end
    sel_found = 1'b0;
    sel_ba    = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_BANKS; k++) begin
      idx = rr_ptr_q + BA_WIDTH'(k);  // wraps naturally since NUM_BANKS is a power of two
      if (!sel_found && win_mask[idx]) begin
        sel_found = 1'b1;
        sel_ba    = idx;
      end
    end
    if (sel_type == CmdRd && !rd_elig[sel_ba]) sel_type = CmdWr;
    gnt_valid = sel_found && rst_ni;
  end

  always_comb begin
    act_gnt_o = '0;
    rd_gnt_o  = '0;
    wr_gnt_o  = '0;
    pre_gnt_o = '0;
    ref_gnt_o = '0;
    if (gnt_valid) begin
      unique case (sel_type)
        CmdAct:  act_gnt_o[sel_ba] = 1'b1;
        CmdRd:   rd_gnt_o[sel_ba]  = 1'b1;
        CmdWr:   wr_gnt_o[sel_ba]  = 1'b1;
        CmdPre:  pre_gnt_o[sel_ba] = 1'b1;
        CmdRef:  ref_gnt_o[sel_ba] = 1'b1;
        default: ;
      endcase
    end
  end

  // Counters saturate at zero; a grant load takes precedence over the decrement.
  always_comb begin
    rrd_cnt_d = (rrd_cnt_q != '0) ? rrd_cnt_q - CNT_WIDTH'(1) : rrd_cnt_q;
    ccd_cnt_d = (ccd_cnt_q != '0) ? ccd_cnt_q - CNT_WIDTH'(1) : ccd_cnt_q;
    wtr_cnt_d = (wtr_cnt_q != '0) ? wtr_cnt_q - CNT_WIDTH'(1) : wtr_cnt_q;
    rtw_cnt_d = (rtw_cnt_q != '0) ? rtw_cnt_q - CNT_WIDTH'(1) : rtw_cnt_q;
`ifdef SAL_FAW_EN
    faw_wptr_d = faw_wptr_q;
    for (int i = 0; i < 4; i++) begin
      faw_cnt_d[i] = (faw_cnt_q[i] != '0) ? faw_cnt_q[i] - CNT_WIDTH'(1) : faw_cnt_q[i];
    end
`endif
    rr_ptr_d    = rr_ptr_q;
    cmd_valid_d = gnt_valid;
    cmd_type_d  = cmd_type_q;
    cmd_ba_d    = cmd_ba_q;
    cmd_ra_d    = cmd_ra_q;
    cmd_ca_d    = cmd_ca_q;
    cmd_id_d    = cmd_id_q;
    cmd_len_d   = cmd_len_q;
    if (gnt_valid) begin
      rr_ptr_d   = sel_ba + BA_WIDTH'(1);
      cmd_type_d = sel_type;
      cmd_ba_d   = sel_ba;
      cmd_ra_d   = ra_i[sel_ba*RA_WIDTH +: RA_WIDTH];
      cmd_ca_d   = ca_i[sel_ba*CA_WIDTH +: CA_WIDTH];
      cmd_id_d   = id_i[sel_ba*ID_WIDTH +: ID_WIDTH];
      cmd_len_d  = len_i[sel_ba*LEN_WIDTH +: LEN_WIDTH];
      if (sel_type == CmdAct) begin
        rrd_cnt_d = t_rrd_m1_i;
`ifdef SAL_FAW_EN
        faw_cnt_d[faw_wptr_q] = t_faw_m1_i;
        faw_wptr_d            = faw_wptr_q + 2'd1;
`endif
      end
      if (sel_type == CmdRd) begin
        ccd_cnt_d = t_ccd_m1_i;
        rtw_cnt_d = t_rtw_m1_i;
      end
      if (sel_type == CmdWr) begin
        ccd_cnt_d = t_ccd_m1_i;
        wtr_cnt_d = t_wtr_m1_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rrd_cnt_q   <= '0;
      ccd_cnt_q   <= '0;
      wtr_cnt_q   <= '0;
      rtw_cnt_q   <= '0;
      rr_ptr_q    <= '0;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= '0;
      cmd_ba_q    <= '0;
      cmd_ra_q    <= '0;
      cmd_ca_q    <= '0;
      cmd_id_q    <= '0;
      cmd_len_q   <= '0;
`ifdef SAL_FAW_EN
      faw_cnt_q   <= '0;
      faw_wptr_q  <= '0;
`endif
    end else begin
      rrd_cnt_q   <= rrd_cnt_d;
      ccd_cnt_q   <= ccd_cnt_d;
      wtr_cnt_q   <= wtr_cnt_d;
      rtw_cnt_q   <= rtw_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      cmd_ba_q    <= cmd_ba_d;
      cmd_ra_q    <= cmd_ra_d;
      cmd_ca_q    <= cmd_ca_d;
      cmd_id_q    <= cmd_id_d;
      cmd_len_q   <= cmd_len_d;
`ifdef SAL_FAW_EN
      faw_cnt_q   <= faw_cnt_d;
      faw_wptr_q  <= faw_wptr_d;
`endif
    end
  end

  assign cmd_valid_o = cmd_valid_q;
  assign cmd_type_o  = cmd_type_q;
  assign cmd_ba_o    = cmd_ba_q;
  assign cmd_ra_o    = cmd_ra_q;
  assign cmd_ca_o    = cmd_ca_q;
  assign cmd_id_o    = cmd_id_q;
  assign cmd_len_o   = cmd_len_q;

endmodule

// File: tb/tb_sal_sched_arbiter.sv
// Self-checking bench for sal_sched_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a time-stamp based reference model.
module tb_sal_sched_arbiter;
  localparam int NB   = 8;
  localparam int RAW  = 16;
  localparam int CAW  = 10;
  localparam int IDW  = 4;
  localparam int LENW = 8;
  localparam int CW   = 8;
  localparam int BAW  = 3;

  logic              clk, rst_n;
  logic [NB-1:0]     act_req, rd_req, wr_req, pre_req, ref_req;
  logic [NB-1:0]     act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  logic [NB*RAW-1:0] ra;
  logic [NB*CAW-1:0] ca;
  logic [NB*IDW-1:0] id;
  logic [NB*LENW-1:0] len;
  logic [CW-1:0]     t_rrd, t_ccd, t_wtr, t_rtw, t_faw;
  logic              cmd_valid;
  logic [2:0]        cmd_type;
  logic [BAW-1:0]    cmd_ba;
  logic [RAW-1:0]    cmd_ra;
  logic [CAW-1:0]    cmd_ca;
  logic [IDW-1:0]    cmd_id;
  logic [LENW-1:0]   cmd_len;

  sal_sched_arbiter #(
    .NUM_BANKS(NB), .RA_WIDTH(RAW), .CA_WIDTH(CAW), .ID_WIDTH(IDW), .LEN_WIDTH(LENW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .act_req_i(act_req), .rd_req_i(rd_req), .wr_req_i(wr_req), .pre_req_i(pre_req),
    .ref_req_i(ref_req), .ra_i(ra), .ca_i(ca), .id_i(id), .len_i(len),
    .act_gnt_o(act_gnt), .rd_gnt_o(rd_gnt), .wr_gnt_o(wr_gnt), .pre_gnt_o(pre_gnt),
    .ref_gnt_o(ref_gnt),
    .t_rrd_m1_i(t_rrd), .t_ccd_m1_i(t_ccd), .t_wtr_m1_i(t_wtr), .t_rtw_m1_i(t_rtw),
`ifdef SAL_FAW_EN
    .t_faw_m1_i(t_faw),
`endif
    .cmd_valid_o(cmd_valid), .cmd_type_o(cmd_type), .cmd_ba_o(cmd_ba), .cmd_ra_o(cmd_ra),
    .cmd_ca_o(cmd_ca), .cmd_id_o(cmd_id), .cmd_len_o(cmd_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endfunction

  // Bank scheduler stand-ins: class per bank (-1 idle, 0 ACT, 1 RD, 2 WR, 3 PRE, 4 REF).
  int              req_cls [NB];
  logic [RAW-1:0]  b_ra  [NB];
  logic [CAW-1:0]  b_ca  [NB];
  logic [IDW-1:0]  b_id  [NB];
  logic [LENW-1:0] b_len [NB];

  // Reference model: grant times and the timing value in force at each grant.
  int cyc, rr;
  int last_act, last_cas, last_rd, last_wr;
  int m_rrd, m_ccd, m_wtr, m_rtw;
  int faw_t[$], faw_v[$];
  bit e_valid;
  int e_type, e_ba;
  logic [RAW-1:0] e_ra;
  logic [CAW-1:0] e_ca;
  logic [IDW-1:0] e_id;
  logic [LENW-1:0] e_len;

  int act_t[$], rd_t[$], wr_t[$], pre_t[$];
  logic [NB-1:0] d_act, d_rd, d_wr;

  always @(negedge clk) begin
    for (int b = 0; b < NB; b++)
      assert ($countones({act_req[b], rd_req[b], wr_req[b], pre_req[b], ref_req[b]}) <= 1)
        else $error("multi-hot request from bank %0d", b);
  end

  task automatic drive_inputs();
    act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
    for (int b = 0; b < NB; b++) begin
      case (req_cls[b])
        0: act_req[b] = 1'b1;
        1: rd_req[b]  = 1'b1;
        2: wr_req[b]  = 1'b1;
        3: pre_req[b] = 1'b1;
        4: ref_req[b] = 1'b1;
        default: ;
      endcase
      ra[b*RAW +: RAW]    = b_ra[b];
      ca[b*CAW +: CAW]    = b_ca[b];
      id[b*IDW +: IDW]    = b_id[b];
      len[b*LENW +: LENW] = b_len[b];
    end
  endtask

  task automatic new_req(input int b, input int cls);
    req_cls[b] = cls;
    b_ra[b]  = RAW'($urandom);
    b_ca[b]  = CAW'($urandom);
    b_id[b]  = IDW'($urandom);
    b_len[b] = LENW'($urandom);
  endtask

  function automatic void model_pick(output int ty, output int bk);
    bit act_ok, rd_ok, wr_ok;
    int b, t;
    act_ok = (cyc >= last_act + m_rrd + 1);
`ifdef SAL_FAW_EN
    if (faw_t.size() >= 4 && cyc < faw_t[0] + faw_v[0] + 1) act_ok = 0;
`endif
    rd_ok = (cyc >= last_cas + m_ccd + 1) && (cyc >= last_wr + m_wtr + 1);
    wr_ok = (cyc >= last_cas + m_ccd + 1) && (cyc >= last_rd + m_rtw + 1);
    ty = -1; bk = -1;
    for (int c = 0; c < 4 && ty < 0; c++) begin
      for (int k = 0; k < NB && ty < 0; k++) begin
        b = (rr + k) % NB;
        t = req_cls[b];
        if ((c == 0 && ((t == 1 && rd_ok) || (t == 2 && wr_ok))) ||
            (c == 1 && t == 0 && act_ok) || (c == 2 && t == 3) || (c == 3 && t == 4)) begin
          ty = t; bk = b;
        end
      end
    end
  endfunction

  task automatic model_reset();
    cyc = 0; rr = 0;
    last_act = -1000; last_cas = -1000; last_rd = -1000; last_wr = -1000;
    m_rrd = 0; m_ccd = 0; m_wtr = 0; m_rtw = 0;
    faw_t.delete(); faw_v.delete();
    e_valid = 0; e_type = 0; e_ba = 0; e_ra = '0; e_ca = '0; e_id = '0; e_len = '0;
    act_t.delete(); rd_t.delete(); wr_t.delete(); pre_t.delete();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      drive_inputs();
      @(negedge clk);
      chk("reset_gnt", {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt}, '0);
      if (i > 0) chk("reset_cmd_valid", cmd_valid, 0);
      @(posedge clk); #1;
    end
    chk("reset_cmd_fields", {cmd_type, cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len}, '0);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock: check grants and the registered command against the model, then advance it.
  task automatic cycle(input bit refill);
    int ty, bk;
    logic [NB-1:0] ev [5];
    drive_inputs();
    @(negedge clk);
    model_pick(ty, bk);
    for (int c = 0; c < 5; c++) ev[c] = '0;
    if (ty >= 0) ev[ty][bk] = 1'b1;
    chk("act_gnt", act_gnt, ev[0]);
    chk("rd_gnt", rd_gnt, ev[1]);
    chk("wr_gnt", wr_gnt, ev[2]);
    chk("pre_gnt", pre_gnt, ev[3]);
    chk("ref_gnt", ref_gnt, ev[4]);
    chk("cmd_valid", cmd_valid, e_valid);
    chk("cmd_fields", {cmd_type, cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len},
        {3'(e_type), BAW'(e_ba), e_ra, e_ca, e_id, e_len});
    d_act = act_gnt; d_rd = rd_gnt; d_wr = wr_gnt;
    if (|act_gnt) act_t.push_back(cyc);
    if (|rd_gnt)  rd_t.push_back(cyc);
    if (|wr_gnt)  wr_t.push_back(cyc);
    if (|pre_gnt) pre_t.push_back(cyc);
    if (ty >= 0) begin
      e_valid = 1; e_type = ty; e_ba = bk;
      e_ra = b_ra[bk]; e_ca = b_ca[bk]; e_id = b_id[bk]; e_len = b_len[bk];
      rr = (bk + 1) % NB;
      case (ty)
        0: begin
          last_act = cyc; m_rrd = t_rrd;
          faw_t.push_back(cyc); faw_v.push_back(t_faw);
          if (faw_t.size() > 4) begin void'(faw_t.pop_front()); void'(faw_v.pop_front()); end
        end
        1: begin last_cas = cyc; m_ccd = t_ccd; last_rd = cyc; m_rtw = t_rtw; end
        2: begin last_cas = cyc; m_ccd = t_ccd; last_wr = cyc; m_wtr = t_wtr; end
        default: ;
      endcase
      req_cls[bk] = -1;
    end else begin
      e_valid = 0;
    end
    if (refill)
      for (int b = 0; b < NB; b++)
        if (req_cls[b] < 0 && $urandom_range(0, 2) == 0) new_req(b, $urandom_range(0, 4));
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic clear_reqs();
    for (int b = 0; b < NB; b++) new_req(b, -1);
  endtask

  task automatic set_timing(input int rrd, input int ccd, input int wtr, input int rtw,
                            input int faw);
    t_rrd = CW'(rrd); t_ccd = CW'(ccd); t_wtr = CW'(wtr); t_rtw = CW'(rtw); t_faw = CW'(faw);
  endtask

  initial begin
    rst_n = 1'b0;
    set_timing(0, 0, 0, 0, 0);
    clear_reqs();
    model_reset();

    // Reset with every bank requesting RD; bank 0 wins first after release.
    for (int b = 0; b < NB; b++) new_req(b, 1);
    do_reset(3);
    cycle(0);
    chk("first_rd_bank0", d_rd, 8'h01);
    for (int i = 0; i < 8; i++) cycle(0);

    // Round-robin among banks 0 and 2 with constant ACT requests.
    clear_reqs();
    do_reset(2);
    new_req(0, 0); new_req(2, 0);
    cycle(0);
    chk("rr_gnt0", d_act, 8'h01);
    chk("rr_ba0", cmd_ba, 0);
    new_req(0, 0);
    cycle(0);
    chk("rr_gnt1", d_act, 8'h04);
    chk("rr_ba1", cmd_ba, 2);
    new_req(2, 0);
    cycle(0);
    chk("rr_gnt2", d_act, 8'h01);
    chk("rr_ba2", cmd_ba, 0);

    // CAS outranks ACT.
    clear_reqs();
    do_reset(2);
    new_req(3, 2); new_req(1, 0);
    cycle(0);
    chk("prio_wr_first", d_wr, 8'h08);
    chk("prio_act_held", d_act, 8'h00);
    cycle(0);
    chk("prio_act_next", d_act, 8'h02);

    // tRRD-blocked ACTs let a PRE through in the gap.
    clear_reqs();
    set_timing(4, 0, 0, 0, 0);
    do_reset(2);
    new_req(1, 0); new_req(2, 0); new_req(4, 0);
    cycle(0);
    new_req(5, 3);
    for (int i = 0; i < 11; i++) cycle(0);
    chk("rrd_gap1", act_t[1] - act_t[0], 5);
    chk("rrd_gap2", act_t[2] - act_t[1], 5);
    chk("rrd_pre_in_gap", pre_t[0], 1);

    // Write-to-read and read-to-write turnaround.
    clear_reqs();
    set_timing(0, 1, 6, 2, 0);
    do_reset(2);
    new_req(0, 2); new_req(1, 1);
    for (int i = 0; i < 8; i++) cycle(0);
    new_req(2, 2);
    for (int i = 0; i < 6; i++) cycle(0);
    chk("ta_wr0", wr_t[0], 0);
    chk("ta_rd_after_wtr", rd_t[0], 7);
    chk("ta_wr_after_rtw", wr_t[1], 10);

    // Four-activate window (or plain back-to-back ACTs without it).
    clear_reqs();
    set_timing(0, 0, 0, 0, 19);
    do_reset(2);
    for (int b = 0; b < NB; b++) new_req(b, 0);
    for (int i = 0; i < 26; i++) cycle(0);
    chk("faw_act3", act_t[3], 3);
`ifdef SAL_FAW_EN
    chk("faw_act4", act_t[4], 20);
    chk("faw_act7", act_t[7], 23);
`else
    chk("faw_act4", act_t[4], 4);
    chk("faw_act7", act_t[7], 7);
`endif

    // Randomized traffic with timing changes and occasional mid-count resets.
    clear_reqs();
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0)
        set_timing($urandom_range(0, 9), $urandom_range(0, 6), $urandom_range(0, 12),
                   $urandom_range(0, 8), $urandom_range(0, 40));
      if (i % 900 == 899) do_reset(2);
      cycle(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
